// File: rtl/kia_pkg.sv
// kia_pkg: shared constants and receiver state encoding for the keyboard interface adapter
package kia_pkg;
  localparam logic ADR_STATUS = 1'b0;
  localparam logic ADR_DATA = 1'b1;
  localparam int NE = 0;
  localparam int FULL = 1;
  localparam int OVR = 2;
  localparam int PERR = 3;
  localparam int FRAME_BITS = 11;
  typedef enum logic {IDLE, SHIFT} rx_state_t;
endpackage

// File: rtl/kia_fifo.sv
// kia_fifo: 8-bit synchronous FIFO; push and pop on the same edge are both honoured even when full
module kia_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) && (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp[DEPTH_LOG2-1:0]];
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk_i) if (do_push) mem[wp[DEPTH_LOG2-1:0]] <= din;
endmodule

// File: rtl/kia_ps2_adapter.sv
// kia_ps2_adapter: PS/2 receiver + scan-code FIFO behind a 16-bit Wishbone slave.
// Define KIA_PARITY_CHECK_EN to drop odd-parity failures and report them via PERR.
module kia_ps2_adapter
  import kia_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic        adr_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        ack_o,
  input  logic        ps2c_i,
  input  logic        ps2d_i
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic c_prev, fall, sd;
  rx_state_t state;
  logic [3:0] bcnt;
  logic [7:0] sr, dout;
  logic par, frame_end, push, pop, empty, full, acc, rd, w_status, ovr, ovr_set, perr, unused;
  logic [TW-1:0] tcnt;
  assign fall = c_prev & ~c_sync[SYNC_STAGES-1];
  assign sd = d_sync[SYNC_STAGES-1];
  assign frame_end = fall && state == SHIFT && bcnt == 4'(FRAME_BITS - 1);
  assign acc = cyc_i & stb_i & ~ack_o;
  assign rd = acc & ~we_i;
  assign pop = rd & (adr_i == ADR_DATA);
  assign w_status = acc & we_i & (adr_i == ADR_STATUS) & sel_i[0];
  assign ovr_set = push & full & ~pop;
  assign unused = ^{sel_i[1], dat_i, par};
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      c_sync <= '1;
      d_sync <= '1;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], ps2c_i};
      d_sync <= {d_sync[SYNC_STAGES-2:0], ps2d_i};
      c_prev <= c_sync[SYNC_STAGES-1];
    end
  end
  // bcnt 1..8 shift data LSB first, 9 captures parity, 10 is the stop bit
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state <= IDLE;
      bcnt <= '0;
      sr <= '0;
      par <= 1'b0;
      tcnt <= '0;
    end else if (fall) begin
      tcnt <= '0;
      if (state == IDLE) begin
        if (!sd) begin
          state <= SHIFT;
          bcnt <= 4'd1;
        end
      end else if (bcnt == 4'(FRAME_BITS - 1)) begin
        state <= IDLE;
        bcnt <= '0;
      end else begin
        bcnt <= bcnt + 4'd1;
        if (bcnt == 4'(FRAME_BITS - 2)) par <= sd;
        else sr <= {sd, sr[7:1]};
      end
    end else if (state == SHIFT) begin
      if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state <= IDLE;
        bcnt <= '0;
        tcnt <= '0;
      end else tcnt <= tcnt + 1'b1;
    end
  end
`ifdef KIA_PARITY_CHECK_EN
  logic par_ok;
  assign par_ok = ^{sr, par};
  assign push = frame_end & sd & par_ok;
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) perr <= 1'b0;
    else perr <= (frame_end & sd & ~par_ok) | (perr & ~(w_status & dat_i[PERR]));
  end
`else
  assign push = frame_end & sd;
  assign perr = 1'b0;
`endif
  kia_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk_i(clk_i), .res_i(res_i), .push(push), .pop(pop),
    .din(sr), .dout(dout), .empty(empty), .full(full)
  );
  // set beats clear on OVR; dat_o captures pre-edge flags on the edge raising ack
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      ovr <= 1'b0;
    end else begin
      ack_o <= ~ack_o & cyc_i & stb_i;
      if (rd) dat_o <= (adr_i == ADR_DATA) ? (empty ? 16'h0000 : {8'h00, dout}) : {12'h000, perr, ovr, full, ~empty};
      ovr <= ovr_set | (ovr & ~(w_status & dat_i[OVR]));
    end
  end
endmodule

// File: tb/tb_kia_ps2_adapter.sv
// tb_kia_ps2_adapter: table-driven bench for kia_ps2_adapter plus timeout and reset sequences
module tb_kia_ps2_adapter;
  localparam int TO = 300;
  logic clk_i = 1'b0, res_i = 1'b1, cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, adr_i = 1'b0;
  logic [1:0] sel_i = 2'b00;
  logic [15:0] dat_i = 16'h0000;
  logic [15:0] dat_o;
  logic ack_o;
  logic ps2c_i = 1'b1, ps2d_i = 1'b1;
  int total = 0, bad = 0;
  typedef struct {
    logic is_frame;
    logic [7:0] b;
    logic par_bad;
    logic we;
    logic adr;
    logic [15:0] wdat;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];

  kia_ps2_adapter #(.FIFO_DEPTH_LOG2(4), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .res_i(res_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .ps2c_i(ps2c_i), .ps2d_i(ps2d_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk_i) ps2d_i = b;
    repeat (4) @(negedge clk_i);
    ps2c_i = 1'b0;
    repeat (4) @(negedge clk_i);
    ps2c_i = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic pbad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ pbad);
    ps2_bit(1'b1);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic bus(input logic we, input logic adr, input logic [15:0] wd, output logic [15:0] rd);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = 2'b01; dat_i = wd;
    @(posedge clk_i); #1;
    chk("ack_rise", {15'd0, ack_o}, 16'd1);
    rd = dat_o;
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ack_fall", {15'd0, ack_o}, 16'd0);
  endtask

  function automatic void add_frame(input logic [7:0] b, input logic pbad);
    tbl.push_back('{1'b1, b, pbad, 1'b0, 1'b0, 16'h0, 16'h0});
  endfunction

  function automatic void add_bus(input logic we, input logic adr, input logic [15:0] wd, input logic [15:0] e);
    tbl.push_back('{1'b0, 8'h00, 1'b0, we, adr, wd, e});
  endfunction

  initial begin
    logic [15:0] rd;
    add_frame(8'h1C, 1'b0);
    add_bus(1'b0, 1'b0, 16'h0, 16'h0001);
    add_bus(1'b0, 1'b1, 16'h0, 16'h001C);
    add_bus(1'b0, 1'b0, 16'h0, 16'h0000);
    for (int i = 1; i <= 17; i++) add_frame(8'(i), 1'b0);
    add_bus(1'b0, 1'b0, 16'h0, 16'h0007);
    for (int i = 1; i <= 16; i++) add_bus(1'b0, 1'b1, 16'h0, 16'(i));
    add_bus(1'b1, 1'b0, 16'h0004, 16'h0);
    add_bus(1'b0, 1'b0, 16'h0, 16'h0000);
    add_frame(8'h76, 1'b1);
`ifdef KIA_PARITY_CHECK_EN
    add_bus(1'b0, 1'b0, 16'h0, 16'h0008);
    add_bus(1'b0, 1'b1, 16'h0, 16'h0000);
    add_bus(1'b1, 1'b0, 16'h0008, 16'h0);
    add_bus(1'b0, 1'b0, 16'h0, 16'h0000);
`else
    add_bus(1'b0, 1'b0, 16'h0, 16'h0001);
    add_bus(1'b0, 1'b1, 16'h0, 16'h0076);
`endif
    add_bus(1'b0, 1'b1, 16'h0, 16'h0000);
    add_bus(1'b1, 1'b1, 16'hFFFF, 16'h0);
    add_frame(8'h29, 1'b0);
    add_bus(1'b0, 1'b1, 16'h0, 16'h0029);
    add_bus(1'b0, 1'b0, 16'h0, 16'h0000);

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_ack", {15'd0, ack_o}, 16'd0);
    chk("reset_dat", dat_o, 16'h0000);
    @(negedge clk_i) res_i = 1'b0;
    bus(1'b0, 1'b0, 16'h0, rd);
    chk("reset_status", rd, 16'h0000);

    foreach (tbl[i]) begin
      if (tbl[i].is_frame) frame(tbl[i].b, tbl[i].par_bad);
      else begin
        bus(tbl[i].we, tbl[i].adr, tbl[i].wdat, rd);
        if (!tbl[i].we) chk($sformatf("vec%0d", i), rd, tbl[i].exp);
      end
    end

    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (TO + 10) @(negedge clk_i);
    frame(8'h5A, 1'b0);
    bus(1'b0, 1'b1, 16'h0, rd);
    chk("timeout_data", rd, 16'h005A);
    bus(1'b0, 1'b0, 16'h0, rd);
    chk("timeout_status", rd, 16'h0000);

    frame(8'h33, 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 1'b0;
    @(posedge clk_i); #1;
    chk("pre_rst_ack", {15'd0, ack_o}, 16'd1);
    chk("pre_rst_dat", dat_o, 16'h0001);
    #2 res_i = 1'b1;
    #1;
    chk("async_rst_ack", {15'd0, ack_o}, 16'd0);
    chk("async_rst_dat", dat_o, 16'h0000);
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0;
    res_i = 1'b0;
    bus(1'b0, 1'b0, 16'h0, rd);
    chk("post_rst_status", rd, 16'h0000);
    frame(8'h45, 1'b0);
    bus(1'b0, 1'b1, 16'h0, rd);
    chk("post_rst_data", rd, 16'h0045);
    bus(1'b0, 1'b0, 16'h0, rd);
    chk("post_rst_empty", rd, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
